// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Counter must be able to hold the value WIDTH.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_8bit_full_adder.sv
// One-bit full adder used as the per-bit stage of the serial subtractor.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial a - b (LSB first, a + ~b + 1) through a single full adder.
// Optional signed overflow output enabled by defining SERIAL_SUB_OVERFLOW_EN.
module serial_subtractor_8bit
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);

    state_e             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   res_q;
    logic [WIDTH-1:0]   res_d;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   diff_q;
    logic               borrow_q;
    logic               fa_sum;
    logic               fa_cout;
    logic               last_bit;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic               ovf_q;
`endif

    // Operand registers shift right, so the adder always sees bit 0.
    full_adder u_fa (
        .a     (a_q[0]),
        .b     (~b_q[0]),
        .c_in  (carry_q),
        .sum   (fa_sum),
        .c_out (fa_cout)
    );

    always_comb begin
        res_d    = {fa_sum, res_q[WIDTH-1:1]};
        last_bit = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Result is staged in res_q and only published to diff on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= 1'b1;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    a_q     <= a_q >> 1;
                    b_q     <= b_q >> 1;
                    res_q   <= res_d;
                    carry_q <= fa_cout;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        diff_q   <= res_d;
                        borrow_q <= ~fa_cout;
`ifdef SERIAL_SUB_OVERFLOW_EN
                        // Carry into the MSB is the carry entering this last step.
                        ovf_q    <= carry_q ^ fa_cout;
`endif
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign overflow = ovf_q;
`endif

endmodule

// File: doc/serial_subtractor_8bit.md
SERIAL_SUBTRACTOR_8BIT -- requirements
Module: serial_subtractor_8bit

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin a subtraction, sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  minuend, captured on accepted start.
REQ-006 SHALL have port b  input  WIDTH  subtrahend, captured on accepted start.
REQ-007 SHALL have port busy  output  1  high while an operation is in progress (SHIFT or DONE).
REQ-008 SHALL have port done  output  1  one-cycle pulse: diff/borrow valid.
REQ-009 SHALL have port diff  output  WIDTH  a - b modulo 2^WIDTH, held until the next accepted start.
REQ-010 SHALL have port borrow  output  1  high when a < b unsigned, held with diff.

Function
REQ-011 SHALL compute a - b bit-serially, LSB first, one bit per clock, as a + ~b + 1 through a single 1-bit full adder.
REQ-012 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-013 IDLE: start=1 captures a, b; loads carry=1, bit counter=0; moves to SHIFT on the next edge.
REQ-014 SHIFT: each cycle adds a[i], ~b[i] and carry, shifts the sum bit into the result register from the MSB end, updates carry, increments counter.
REQ-015 SHIFT SHALL last exactly WIDTH cycles, then move to DONE.
REQ-016 DONE: done=1 for exactly one cycle; diff and borrow=~final carry are valid in that cycle; next state IDLE.
REQ-017 Latency from start-accepting edge to done=1 SHALL be WIDTH+1 cycles; start can be accepted again in the cycle after DONE.
REQ-018 start while busy SHALL be ignored, with no change to captured operands or the running computation.
REQ-019 Changes on a and b after capture SHALL NOT affect the result.
REQ-020 diff and borrow SHALL change only at the DONE transition; intermediate shift values SHALL NOT be visible on diff.
REQ-021 Equal operands SHALL give diff=0, borrow=0; a=0, b=2^WIDTH-1 SHALL give diff=1, borrow=1.

Reset
REQ-022 rst_n=0 SHALL immediately force state IDLE, busy=0, done=0, diff=0, borrow=0, counter=0, carry=0.
REQ-023 Reset mid-operation SHALL abort it with no done pulse; the first start after rst_n rises SHALL compute normally.

Configuration
REQ-024 Macro SERIAL_SUB_OVERFLOW_EN, when defined, SHALL add output port overflow  1  signed two's-complement overflow, computed as carry-into-MSB XOR carry-out-of-MSB, reset 0, updated and held exactly like borrow.
REQ-025 Without SERIAL_SUB_OVERFLOW_EN, the overflow port and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-026 Package serial_sub_pkg SHALL hold the FSM state typedef (IDLE, SHIFT, DONE) and the default WIDTH constant.
REQ-027 The existing full_adder module (ports a, b, c_in, sum, c_out) SHALL be instantiated once as the only sub-module for the per-bit stage.
REQ-028 The counter SHALL be sized $clog2(WIDTH+1) bits.

Verification
REQ-029 a=0x05, b=0x03, start for 1 cycle -> done exactly 9 cycles later, diff=0x02, borrow=0.
REQ-030 a=0x03, b=0x05 -> diff=0xFE, borrow=1; overflow=0 with the macro defined.
REQ-031 a=0x80, b=0x01 -> diff=0x7F, borrow=0; with the macro defined, overflow=1.
REQ-032 a=0x10, b=0x01, then start pulsed with a=0xFF, b=0xFF at cycle 3 -> single done with diff=0x0F; second start ignored.
REQ-033 rst_n low at cycle 4 of an operation -> busy, done, diff, borrow all 0 asynchronously; no done pulse; next op a=0x00, b=0xFF -> diff=0x01, borrow=1.
REQ-034 Back-to-back: start held high continuously -> done every WIDTH+2 cycles, each result correct for the operands present when its start was accepted.
